car_count_sensor: RTL and testbench

//   Upstream stage of the highway/city-road traffic light controller.

---
 rtl/car_count_sensor_if.sv | 41 ++++
 rtl/car_count_sensor.sv | 142 ++++++++++++++
 tb/tb_car_count_sensor.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/car_count_sensor_if.sv
// Sensor/count bundle between the city-road loop detector stage and the controller.
// ovf_pulse exists only when CARCOUNT_OVF_EN is defined.
interface car_count_sensor_if;
   logic       sensor_raw;
   logic       city_served;
   logic [2:0] carCount;
   logic       car_present;
`ifdef CARCOUNT_OVF_EN
   logic       ovf_pulse;

   modport master (
      output sensor_raw,
      output city_served,
      input  carCount,
      input  car_present,
      input  ovf_pulse
   );

   modport slave (
      input  sensor_raw,
      input  city_served,
      output carCount,
      output car_present,
      output ovf_pulse
   );
`else
   modport master (
      output sensor_raw,
      output city_served,
      input  carCount,
      input  car_present
   );

   modport slave (
      input  sensor_raw,
      input  city_served,
      output carCount,
      output car_present
   );
`endif
endinterface

// File: rtl/car_count_sensor.sv
// Debounces the city-road loop detector and counts waiting cars (saturating).
// Optional overflow pulse enabled by defining CARCOUNT_OVF_EN.
module car_count_sensor #(
   parameter int DEBOUNCE_CYC = 4,
   parameter int MAX_COUNT    = 5
) (
   input  logic              clock,
   input  logic              reset,
   car_count_sensor_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      ARRIVING,
      PRESENT,
      LEAVING
   } state_t;

   localparam logic [8:0] DEB_W   = 9'(DEBOUNCE_CYC);
   localparam logic [2:0] MAXC    = 3'(MAX_COUNT);
   localparam bit         DEB_ONE = (DEBOUNCE_CYC == 1);

   state_t     r_state;
   state_t     w_state_next;
   logic [7:0] r_deb_cnt;
   logic [7:0] w_deb_next;
   logic [8:0] w_deb_inc;
   logic       w_deb_done;
   logic [2:0] r_count;
   logic [2:0] w_count_next;
   logic       r_present;
   logic       w_present_next;
   logic       w_arrive;

   assign w_deb_inc  = {1'b0, r_deb_cnt} + 9'd1;
   assign w_deb_done = (w_deb_inc >= DEB_W);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_deb_cnt <= 8'd0;
         r_count   <= 3'd0;
         r_present <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_deb_cnt <= w_deb_next;
         r_count   <= w_count_next;
         r_present <= w_present_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_deb_next     = r_deb_cnt;
      w_present_next = r_present;
      w_arrive       = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.sensor_raw) begin
               if (DEB_ONE) begin
                  w_state_next   = PRESENT;
                  w_deb_next     = 8'd0;
                  w_present_next = 1'b1;
                  w_arrive       = 1'b1;
               end else begin
                  w_state_next = ARRIVING;
                  w_deb_next   = 8'd1;
               end
            end
         end
         ARRIVING: begin
            if (!bus.sensor_raw) begin
               w_state_next = IDLE;
               w_deb_next   = 8'd0;
            end else if (w_deb_done) begin
               w_state_next   = PRESENT;
               w_deb_next     = 8'd0;
               w_present_next = 1'b1;
               w_arrive       = 1'b1;
            end else begin
               w_deb_next = w_deb_inc[7:0];
            end
         end
         PRESENT: begin
            if (!bus.sensor_raw) begin
               if (DEB_ONE) begin
                  w_state_next   = IDLE;
                  w_deb_next     = 8'd0;
                  w_present_next = 1'b0;
               end else begin
                  w_state_next = LEAVING;
                  w_deb_next   = 8'd1;
               end
            end
         end
         LEAVING: begin
            // A return to high is the same car bouncing, never a new arrival
            if (bus.sensor_raw) begin
               w_state_next = PRESENT;
               w_deb_next   = 8'd0;
            end else if (w_deb_done) begin
               w_state_next   = IDLE;
               w_deb_next     = 8'd0;
               w_present_next = 1'b0;
            end else begin
               w_deb_next = w_deb_inc[7:0];
            end
         end
         default: begin
            w_state_next = IDLE;
            w_deb_next   = 8'd0;
         end
      endcase
   end

   always_comb begin
      w_count_next = r_count;
      if (bus.city_served) begin
         w_count_next = 3'd0;
      end else if (w_arrive && (r_count < MAXC)) begin
         w_count_next = r_count + 3'd1;
      end
   end

   assign bus.carCount    = r_count;
   assign bus.car_present = r_present;

`ifdef CARCOUNT_OVF_EN
   logic r_ovf;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ovf <= 1'b0;
      end else begin
         r_ovf <= w_arrive && !bus.city_served && (r_count == MAXC);
      end
   end

   assign bus.ovf_pulse = r_ovf;
`endif

endmodule

// File: tb/tb_car_count_sensor.sv
// Scoreboard bench for car_count_sensor (DEBOUNCE_CYC=4, MAX_COUNT=5).
// Overflow checks are active when CARCOUNT_OVF_EN is defined.
module tb_car_count_sensor;

   typedef struct {
      logic [2:0] c;
      logic       p;
      logic       o;
   } exp_t;

   logic clock;
   logic reset;
   int   checks;
   int   errors;
   exp_t q[$];

   car_count_sensor_if bus();

   car_count_sensor #(
      .DEBOUNCE_CYC (4),
      .MAX_COUNT    (5)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: outputs are presented after every clock edge
   always begin
      exp_t e;
      @(posedge clock);
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("carCount", int'(bus.carCount), int'(e.c));
         chk("car_present", int'(bus.car_present), int'(e.p));
`ifdef CARCOUNT_OVF_EN
         chk("ovf_pulse", int'(bus.ovf_pulse), int'(e.o));
`endif
      end
   end

   task automatic step(input logic raw, input logic srv,
                       input logic [2:0] c, input logic p,
                       input logic o);
      exp_t e;
      @(negedge clock);
      bus.sensor_raw  = raw;
      bus.city_served = srv;
      e.c = c;
      e.p = p;
      e.o = o;
      q.push_back(e);
   endtask

   task automatic car_in(input logic [2:0] cb, input logic [2:0] ca,
                         input logic o);
      repeat (3) step(1'b1, 1'b0, cb, 1'b0, 1'b0);
      step(1'b1, 1'b0, ca, 1'b1, o);
   endtask

   task automatic car_out(input logic [2:0] c);
      repeat (3) step(1'b0, 1'b0, c, 1'b1, 1'b0);
      step(1'b0, 1'b0, c, 1'b0, 1'b0);
   endtask

   task automatic drain();
      @(posedge clock);
      #2;
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      reset           = 1'b1;
      bus.sensor_raw  = 1'b0;
      bus.city_served = 1'b0;
      #3;
      chk("rst_count", int'(bus.carCount), 0);
      chk("rst_present", int'(bus.car_present), 0);
      @(negedge clock);
      reset = 1'b0;

      // Glitch: 3 high then low
      repeat (3) step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

      // Single car, then bounce on exit
      car_in(3'd0, 3'd1, 1'b0);
      step(1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 3'd1, 1'b1, 1'b0);
      car_out(3'd1);

      // Plain clear, then 7 cars to saturation
      step(1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
      car_in(3'd0, 3'd1, 1'b0); car_out(3'd1);
      car_in(3'd1, 3'd2, 1'b0); car_out(3'd2);
      car_in(3'd2, 3'd3, 1'b0); car_out(3'd3);
      car_in(3'd3, 3'd4, 1'b0); car_out(3'd4);
      car_in(3'd4, 3'd5, 1'b0); car_out(3'd5);
      car_in(3'd5, 3'd5, 1'b1); car_out(3'd5);
      car_in(3'd5, 3'd5, 1'b1); car_out(3'd5);

      // Clear and arrival on the same edge: clear wins
      repeat (3) step(1'b1, 1'b0, 3'd5, 1'b0, 1'b0);
      step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
      // Served drops with the car still present: not recounted
      step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
      car_out(3'd0);
      car_in(3'd0, 3'd1, 1'b0); car_out(3'd1);
      car_in(3'd1, 3'd2, 1'b0); car_out(3'd2);
      car_in(3'd2, 3'd3, 1'b0); car_out(3'd3);

      // Async reset mid-ARRIVING with carCount=3
      step(1'b1, 1'b0, 3'd3, 1'b0, 1'b0);
      step(1'b1, 1'b0, 3'd3, 1'b0, 1'b0);
      drain();
      reset          = 1'b1;
      bus.sensor_raw = 1'b0;
      #1;
      chk("async_count", int'(bus.carCount), 0);
      chk("async_present", int'(bus.car_present), 0);
      @(negedge clock);
      reset = 1'b0;
      car_in(3'd0, 3'd1, 1'b0);
      car_out(3'd1);

      repeat (2) @(posedge clock);
      #2;
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
